// File: rtl/alu_operand_sequencer_pkg.sv
// Purpose: shared ALU package with sequencer FSM states, ALU select codes, opcode fields and flags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_operand_sequencer_pkg;

   // Sequencer states: opcode, operand A, operand B, one-cycle execute, result hold.
   typedef enum logic [2:0] {
      ST_LOAD_OP = 3'd0,
      ST_LOAD_A  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_HOLD    = 3'd4
   } seq_state_t;

   // ALU select codes carried in opcode bits [2:0]
   localparam logic [2:0] SEL_ADD = 3'b000;
   localparam logic [2:0] SEL_AND = 3'b001;
   localparam logic [2:0] SEL_OR  = 3'b010;
   localparam logic [2:0] SEL_SHL = 3'b011;
   localparam logic [2:0] SEL_SHR = 3'b100;

   // Opcode bit 7 reuses the previous result as operand A
   localparam int CHAIN_BIT = 7;

   // Result flags, packed MSB-first as {carry, negative, zero}
   typedef struct packed {
      logic carry;
      logic negative;
      logic zero;
   } alu_flags_t;

   // Selects above SHR have no defined ALU operation
   function automatic logic is_bad_sel(input logic [2:0] sel);
      return sel > SEL_SHR;
   endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Purpose: collects opcode/A/B bytes, drives a neighbouring ALU, captures and holds its result.
// Latency: 2 cycles from the B-byte transfer edge to out_valid (EXEC, then HOLD).
// Backpressure: in_ready only in load states; the result is held in HOLD until out_ready.
module alu_operand_sequencer
   import alu_operand_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [2:0]        out_flags,
   output logic [CNT_W-1:0]  op_count,
   output logic              sel_err
);

   seq_state_t  state_q;
   seq_state_t  state_d;
   alu_flags_t  flags_q;
   logic        in_xfer;

   assign in_xfer   = in_valid & in_ready;
   assign out_flags = flags_q;

   // State register; reset discards any partially loaded operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD_OP;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_LOAD_OP: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = in_data[CHAIN_BIT] ? ST_LOAD_B : ST_LOAD_A;
            end
         end
         ST_LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_LOAD_OP;
            end
         end
         default: begin
            state_d = ST_LOAD_OP;
         end
      endcase
   end

   // Operand capture, result capture, completion count and sticky select error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         out_result <= '0;
         flags_q    <= '0;
         op_count   <= '0;
         sel_err    <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD_OP: begin
               if (in_xfer) begin
                  alu_sel <= in_data[2:0];
                  // A chained op takes A from the retained previous result
                  if (in_data[CHAIN_BIT]) begin
                     alu_a <= out_result;
                  end
               end
            end
            ST_LOAD_A: begin
               if (in_xfer) begin
                  alu_a <= in_data;
               end
            end
            ST_LOAD_B: begin
               if (in_xfer) begin
                  alu_b <= in_data;
               end
            end
            ST_EXEC: begin
               out_result <= alu_result;
               flags_q    <= '{carry: alu_carry, negative: alu_negative, zero: alu_zero};
               op_count   <= op_count + CNT_W'(1);
               // Undefined selects still complete; only the sticky flag records them
               if (is_bad_sel(alu_sel)) begin
                  sel_err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Purpose: directed self-checking bench for alu_operand_sequencer with a behavioural ALU beside it.
// Latency: checks the 2-cycle B-to-out_valid path and HOLD back-pressure.
// Backpressure: exercises in_valid gaps and out_ready held low in HOLD.
module tb_alu_operand_sequencer;
   import alu_operand_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic [7:0] alu_result;
   logic       alu_zero, alu_negative, alu_carry;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_result;
   logic [2:0] out_flags;
   logic [7:0] op_count;
   logic       sel_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_operand_sequencer #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .alu_negative(alu_negative), .alu_carry(alu_carry),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .op_count(op_count), .sel_err(sel_err)
   );

   // Behavioural ALU: shifts are by one; undefined selects return zero
   always_comb begin
      logic [8:0] sum;
      sum          = {1'b0, alu_a} + {1'b0, alu_b};
      alu_result   = 8'h00;
      alu_carry    = 1'b0;
      case (alu_sel)
         SEL_ADD: begin alu_result = sum[7:0]; alu_carry = sum[8]; end
         SEL_AND: alu_result = alu_a & alu_b;
         SEL_OR:  alu_result = alu_a | alu_b;
         SEL_SHL: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
         SEL_SHR: begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
         default: begin alu_result = 8'h00; alu_carry = 1'b0; end
      endcase
      alu_zero     = (alu_result == 8'h00);
      alu_negative = alu_result[7];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Offer one byte from a negedge; it transfers on the first edge with in_ready high
   task automatic send_byte(input logic [7:0] d, input int gap);
      int n;
      for (int i = 0; i < gap; i++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hEE;
   endtask

   // Full operation with latency, result, flag, count and handshake checks
   task automatic run_op(input string name, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_r, input logic [2:0] exp_f,
                         input logic [7:0] exp_cnt, input logic exp_err, input int gap);
      send_byte(op, gap);
      if (!op[CHAIN_BIT]) send_byte(a, gap);
      send_byte(b, gap);
      check({name, "_exec_valid"}, out_valid, 1'b0);
      check({name, "_exec_ready"}, in_ready, 1'b0);
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, out_valid, 1'b1);
      check({name, "_result"}, out_result, exp_r);
      check({name, "_flags"}, out_flags, exp_f);
      check({name, "_count"}, op_count, exp_cnt);
      check({name, "_sel_err"}, sel_err, exp_err);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_released"}, out_valid, 1'b0);
      check({name, "_ready_again"}, in_ready, 1'b1);
      check({name, "_retained"}, out_result, exp_r);
   endtask

   typedef struct {
      string      name;
      logic [7:0] op, a, b, exp_r;
      logic [2:0] exp_f;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{"add_5_3",     8'h00, 8'h05, 8'h03, 8'h08, 3'b000, 8'd1};
      vecs[1] = '{"add_ff_1",    8'h00, 8'hFF, 8'h01, 8'h00, 3'b101, 8'd2};
      vecs[2] = '{"and_f0_3c",   8'h01, 8'hF0, 8'h3C, 8'h30, 3'b000, 8'd3};
      vecs[3] = '{"chain_shl1",  8'h83, 8'h00, 8'h00, 8'h60, 3'b000, 8'd4};
      vecs[4] = '{"or_40",       8'h02, 8'h40, 8'h00, 8'h40, 3'b000, 8'd5};
      vecs[5] = '{"chain_shl2",  8'h83, 8'h00, 8'h00, 8'h80, 3'b010, 8'd6};
      vecs[6] = '{"chain_shl3",  8'h83, 8'h00, 8'h00, 8'h00, 3'b101, 8'd7};
      vecs[7] = '{"shr_81",      8'h04, 8'h81, 8'h00, 8'h40, 3'b100, 8'd8};
      vecs[8] = '{"ign_bits",    8'h78, 8'h7F, 8'h01, 8'h80, 3'b010, 8'd9};

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_outputs", {alu_a, alu_b, alu_sel, out_result, out_flags, op_count, sel_err}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r,
                vecs[i].exp_f, vecs[i].exp_cnt, 1'b0, (i == 4) ? 3 : 0);
      end

      // HOLD back-pressure: five cycles with out_ready low, in_valid offered but not taken
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      send_byte(8'h20, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1'b1);
         check("bp_result", out_result, 8'h30);
         check("bp_in_ready", in_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      check("bp_count_stable", op_count, 8'd10);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_released", out_valid, 1'b0);
      check("bp_alu_a_kept", alu_a, 8'h10);

      // Reset after the A byte: asynchronous clear, then chain from A=0
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {alu_a, alu_b, alu_sel, out_result, out_flags, op_count, sel_err}, '0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_valid", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_chain", 8'h80, 8'h00, 8'h07, 8'h07, 3'b000, 8'd1, 1'b0, 0);

      // Undefined select sets the sticky error, which survives later good ops
      run_op("bad_sel", 8'h06, 8'h01, 8'h02, 8'h00, 3'b001, 8'd2, 1'b1, 0);
      run_op("after_bad", 8'h00, 8'h01, 8'h01, 8'h02, 3'b000, 8'd3, 1'b1, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("sel_err_cleared", sel_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
